// File: rtl/gate_pkg.sv
// Shared definitions for the gate block family: op-code encoding and width.
package gate_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise logic unit: one of eight two-input functions over WIDTH bits.
// Ops 6 (NOT a) and 7 (pass a) ignore b_i.
module gate_alu
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] y_o
);

    // Select the bitwise function for the captured op code.
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_NOT:  y_o = ~a_i;
            OP_PASS: y_o = a_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/gate_pipe.sv
// Two-stage valid/ready pipelined logic unit.
// S1 holds the captured operands and op; S2 holds the registered result and
// its reductions. Each stage advances only when the stage after it can take
// data, so a full pipeline with an accepting consumer moves all beats in one edge.
module gate_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_t              s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_all_q, y_all_d;
    logic             y_any_q, y_any_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_rdy;
    logic             s2_rdy;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] alu_y;

    gate_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i  (s1_a_q),
        .b_i  (s1_b_q),
        .op_i (s1_op_q),
        .y_o  (alu_y)
    );

    // Stage readiness and handshake qualifiers.
    always_comb begin
        s2_rdy   = !s2_valid_q | out_ready;
        s1_rdy   = !s1_valid_q | s2_rdy;
        in_ready = s1_rdy & !rst;
        in_fire  = in_valid & in_ready;
        out_fire = s2_valid_q & out_ready;
    end

    // Next-state for both stages and the saturating transfer counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        y_all_d    = y_all_q;
        y_any_d    = y_any_q;
        cnt_d      = cnt_q;

        if (s1_rdy) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_a_d  = a;
                s1_b_d  = b;
                s1_op_d = op_t'(op);
            end
        end

        // Result payload only changes when a real beat moves in, so an
        // emptied S2 keeps showing the last result rather than garbage.
        if (s2_rdy) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d     = alu_y;
                y_all_d = &alu_y;
                y_any_d = |alu_y;
            end
        end

        if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset discarding all in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            y_all_q    <= 1'b0;
            y_any_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            y_all_q    <= y_all_d;
            y_any_q    <= y_any_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign y_all     = y_all_q;
    assign y_any     = y_any_q;
    assign xfer_cnt  = cnt_q;

endmodule
